reduce_gate: RTL
================

REDUCE_GATE -- requirements
Module: reduce_gate

Interface
REQ-001 SHALL have parameter BITS, default 1, lane width of each operand and of the result.
REQ-002 SHALL have parameter INPUTS, default 8, number of operands reduced (legal range 2..64).
REQ-003 SHALL have parameter GROUP, default 2, operands combined per clock (legal range 1..INPUTS).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  request presented.
REQ-007 SHALL have port in_ready  output  1  block can accept a request.
REQ-008 SHALL have port mode  input  3  reduction op: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR; 6-7 reserved.
REQ-009 SHALL have port in_data  input  INPUTS*BITS  operand k at bits [k*BITS +: BITS].
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_data  output  BITS  reduction result.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE; in_ready = (state==IDLE).
REQ-015 SHALL accept when in_valid && in_ready, capturing in_data and mode into internal registers; later input changes have no effect.
REQ-016 SHALL on accept load accumulator with identity (all ones for AND/NAND, all zeros otherwise), clear step counter, go to ACCUM.
REQ-017 SHALL in ACCUM combine operands [step*GROUP, step*GROUP+GROUP-1] into accumulator per cycle with base op (AND, OR, XOR), bitwise per lane.
REQ-018 SHALL pad a partial final group (INPUTS not multiple of GROUP) with identity so padding never affects the result.
REQ-019 SHALL take STEPS = ceil(INPUTS/GROUP) ACCUM cycles, then go to DONE; out_valid rises exactly STEPS cycles after the accepting edge.
REQ-020 SHALL in DONE drive out_valid=1 and out_data = accumulator, inverted for NAND/NOR/XNOR; out_data stable while out_valid && !out_ready.
REQ-021 SHALL leave DONE for IDLE on out_valid && out_ready; no new request accepted in that same cycle (in_ready low in DONE).
REQ-022 SHALL drive out_data to 0 whenever out_valid=0.
REQ-023 SHALL treat reserved modes 6-7 as NAND.
REQ-024 SHALL, when GROUP==INPUTS, complete in one ACCUM cycle (STEPS=1).

Reset
REQ-025 SHALL on reset_n low immediately force state IDLE, accumulator 0, step counter 0, out_valid 0, out_data 0, busy 0; in_ready 1 after reset release.
REQ-026 SHALL abort an in-flight reduction on reset with no result delivered; first request after release starts fresh.

Structure
REQ-027 SHALL take the mode encoding (enum) and identity/invert helper constants from shared package reduce_gate_pkg.
REQ-028 SHALL instantiate one sub-module reduce_group: combinational GROUP-operand, BITS-wide reduction with per-operand enable for padding.
REQ-029 SHALL size the step counter as $clog2(STEPS+1) bits; no arithmetic wraps within legal parameters.

Verification
REQ-030 SHALL check BITS=1, INPUTS=8, GROUP=2, mode NAND, in_data=8'hFF -> out_data 0, out_valid 4 cycles after accept; 8'hFE -> 1.
REQ-031 SHALL check BITS=4, INPUTS=3, GROUP=2, mode XOR, operands 4'h1,4'h2,4'h4 -> out_data 4'h7 after 2 cycles (padding harmless); XNOR -> 4'h8.
REQ-032 SHALL check out_ready held low 5 cycles in DONE -> out_valid and out_data stable, in_ready 0; in_data changes during ACCUM ignored.
REQ-033 SHALL check reset_n pulsed low mid-ACCUM -> out_valid 0, busy 0 asynchronously; next request of 8'hFF AND yields 1.
REQ-034 SHALL check GROUP=INPUTS=8, modes OR/NOR on 8'h00 -> 0/1 after 1 cycle; mode 7 behaves as NAND.
REQ-035 SHALL check back-to-back requests with in_valid held high -> second accepted only in IDLE cycle after out handshake, results in order.

Source files
------------

// File: rtl/reduce_gate_pkg.sv
// reduce_gate_pkg: shared mode/state encodings and op helpers for reduce_gate
package reduce_gate_pkg;
  typedef enum logic [2:0] {M_AND, M_NAND, M_OR, M_NOR, M_XOR, M_XNOR} mode_t;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR} op_t;
  function automatic op_t base_op(input logic [2:0] m);
    return (m == M_OR || m == M_NOR) ? OP_OR : (m == M_XOR || m == M_XNOR) ? OP_XOR : OP_AND;
  endfunction
  // reserved codes 6-7 fall into the inverted-AND (NAND) path
  function automatic logic inverts(input logic [2:0] m);
    return m == M_NAND || m == M_NOR || m == M_XNOR || m > M_XNOR;
  endfunction
  function automatic logic ident_ones(input op_t op);
    return op == OP_AND;
  endfunction
endpackage

// File: rtl/reduce_group.sv
// reduce_group: combinational GROUP-operand, BITS-wide reduction; disabled operands act as identity
//   op   : base operation (AND/OR/XOR)
//   data : GROUP operands, operand k at [k*BITS +: BITS]
//   en   : per-operand enable, low for padding slots
//   y    : lane-wise reduction of enabled operands
module reduce_group
  import reduce_gate_pkg::*;
#(
  parameter int BITS  = 1,
  parameter int GROUP = 2
) (
  input  op_t                   op,
  input  logic [GROUP*BITS-1:0] data,
  input  logic [GROUP-1:0]      en,
  output logic [BITS-1:0]       y
);
  always_comb begin
    y = ident_ones(op) ? '1 : '0;
    for (int k = 0; k < GROUP; k++)
      if (en[k])
        y = op == OP_AND ? y & data[k*BITS +: BITS] :
            op == OP_OR  ? y | data[k*BITS +: BITS] : y ^ data[k*BITS +: BITS];
  end
endmodule

// File: rtl/reduce_gate.sv
// reduce_gate: multi-cycle bitwise reduction of INPUTS operands, GROUP per clock, valid/ready handshake
//   clk, reset_n        : clock, async active-low reset
//   in_valid/in_ready   : request handshake; mode/in_data captured on accept
//   out_valid/out_ready : result handshake; out_data is zero when out_valid is low
//   busy                : high whenever not IDLE
module reduce_gate
  import reduce_gate_pkg::*;
#(
  parameter int BITS   = 1,
  parameter int INPUTS = 8,
  parameter int GROUP  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             mode,
  input  logic [INPUTS*BITS-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITS-1:0]        out_data,
  output logic                   busy
);
  localparam int STEPS = (INPUTS + GROUP - 1) / GROUP;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int GW    = GROUP * BITS;
  localparam int PW    = STEPS * GW;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q;
  logic [BITS-1:0]        acc_q, grp_y;
  logic [INPUTS*BITS-1:0] data_q;
  logic [PW-1:0]          padded;
  logic [GW-1:0]          grp;
  logic [GROUP-1:0]       en;
  op_t                    op_q;
  logic                   inv_q, accept, last;
  assign accept = in_valid && in_ready;
  assign last   = cnt_q == CW'(STEPS - 1);
  assign padded = PW'(data_q);
  assign grp    = GW'(padded >> (int'(cnt_q) * GW));
  // slots beyond the last real operand are disabled so they contribute identity
  always_comb begin
    en = '0;
    for (int k = 0; k < GROUP; k++) en[k] = int'(cnt_q) * GROUP + k < INPUTS;
  end
  reduce_group #(.BITS(BITS), .GROUP(GROUP)) u_group (
    .op  (op_q),
    .data(grp),
    .en  (en),
    .y   (grp_y)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  always_comb
    state_d = state_q == IDLE  ? (in_valid ? ACCUM : IDLE) :
              state_q == ACCUM ? (last ? DONE : ACCUM) :
              state_q == DONE  ? (out_ready ? IDLE : DONE) : IDLE;
  always_comb begin
    in_ready  = state_q == IDLE;
    busy      = state_q != IDLE;
    out_valid = state_q == DONE;
    out_data  = out_valid ? (inv_q ? ~acc_q : acc_q) : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      op_q   <= OP_AND;
      inv_q  <= 1'b0;
    end else if (accept) begin
      data_q <= in_data;
      op_q   <= base_op(mode);
      inv_q  <= inverts(mode);
      acc_q  <= ident_ones(base_op(mode)) ? '1 : '0;
      cnt_q  <= '0;
    end else if (state_q == ACCUM) begin
      acc_q <= op_q == OP_AND ? acc_q & grp_y : op_q == OP_OR ? acc_q | grp_y : acc_q ^ grp_y;
      cnt_q <= cnt_q + 1'b1;
    end
endmodule
